// File: rtl/clock_edge_monitor_if.sv
// clock_edge_monitor_if: slow-clock input and measurement outputs of clock_edge_monitor.
// high_time/high_valid exist only when CLKMON_DUTY_EN is defined.
interface clock_edge_monitor_if #(parameter int PERIOD_W = 16);
   logic sclk;
   logic rise_pulse;
   logic fall_pulse;
   logic [PERIOD_W-1:0] period;
   logic period_valid;
   logic locked;
   logic clk_lost;
   logic jitter_err;
`ifdef CLKMON_DUTY_EN
   logic [PERIOD_W-1:0] high_time;
   logic high_valid;
   modport master(input sclk, output rise_pulse, fall_pulse, period, period_valid, locked, clk_lost,
                  jitter_err, high_time, high_valid);
   modport slave(output sclk, input rise_pulse, fall_pulse, period, period_valid, locked, clk_lost,
                 jitter_err, high_time, high_valid);
`else
   modport master(input sclk, output rise_pulse, fall_pulse, period, period_valid, locked, clk_lost,
                  jitter_err);
   modport slave(output sclk, input rise_pulse, fall_pulse, period, period_valid, locked, clk_lost,
                 jitter_err);
`endif
endinterface

// File: rtl/clock_edge_monitor.sv
// clock_edge_monitor: synchronizes a slow external clock, strobes its edges, measures its period
// and tracks lock; CLKMON_DUTY_EN adds high-time measurement.
module clock_edge_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int PERIOD_W = 16,
   parameter int TIMEOUT = 1023,
   parameter int LOCK_COUNT = 4,
   parameter int TOL = 1
) (
   input logic in_clk,
   input logic reset_n,
   clock_edge_monitor_if.master mon
);
   typedef enum logic [1:0] {NO_CLK, ACQUIRE, LOCKED} state_t;
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam logic [PERIOD_W-1:0] MAX = '1;
   localparam logic [PERIOD_W-1:0] TIMEOUT_W = PERIOD_W'(TIMEOUT);
   localparam logic [PERIOD_W:0] TOL_W = (PERIOD_W + 1)'(TOL);
   state_t state, state_nx;
   logic [GW-1:0] good_cnt, good_nx;
   logic [SYNC_STAGES-1:0] sync;
   logic prev, rise, fall, timeout, in_tol, pv_nx, jerr_nx;
   logic [PERIOD_W-1:0] cnt, meas;
   logic [PERIOD_W:0] dev;
   assign rise = sync[SYNC_STAGES-1] & ~prev;
   assign fall = ~sync[SYNC_STAGES-1] & prev;
   assign meas = cnt == MAX ? MAX : cnt + 1'b1;
   // widened by one bit so the absolute difference cannot wrap
   assign dev = meas > mon.period ? {1'b0, meas} - {1'b0, mon.period} : {1'b0, mon.period} - {1'b0, meas};
   assign in_tol = dev <= TOL_W;
   assign timeout = !rise && cnt >= TIMEOUT_W;
   always_ff @(posedge in_clk or negedge reset_n)
      if (!reset_n) begin
         state <= NO_CLK;
         good_cnt <= '0;
      end else begin
         state <= state_nx;
         good_cnt <= good_nx;
      end
   // good_cnt == 0 in ACQUIRE marks that no period has been measured since leaving NO_CLK
   always_comb begin
      state_nx = state;
      good_nx = good_cnt;
      if (rise) begin
         if (state == NO_CLK) begin
            state_nx = ACQUIRE;
            good_nx = '0;
         end else if (state == ACQUIRE) begin
            good_nx = (good_cnt == '0 || !in_tol) ? GW'(1) : good_cnt + 1'b1;
            state_nx = good_nx == GW'(LOCK_COUNT) ? LOCKED : ACQUIRE;
         end else if (!in_tol) begin
            state_nx = ACQUIRE;
            good_nx = GW'(1);
         end
      end else if (timeout) begin
         state_nx = NO_CLK;
         good_nx = '0;
      end
   end
   always_comb begin
      pv_nx = rise && state != NO_CLK;
      jerr_nx = rise && state == LOCKED && !in_tol;
   end
   always_ff @(posedge in_clk or negedge reset_n)
      if (!reset_n) begin
         sync <= '0;
         prev <= 1'b0;
         cnt <= '0;
         mon.rise_pulse <= 1'b0;
         mon.fall_pulse <= 1'b0;
         mon.period <= '0;
         mon.period_valid <= 1'b0;
         mon.jitter_err <= 1'b0;
         mon.locked <= 1'b0;
         mon.clk_lost <= 1'b1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], mon.sclk};
         prev <= sync[SYNC_STAGES-1];
         cnt <= rise ? '0 : (cnt == MAX ? cnt : cnt + 1'b1);
         mon.rise_pulse <= rise;
         mon.fall_pulse <= fall;
         if (pv_nx) mon.period <= meas;
         mon.period_valid <= pv_nx;
         mon.jitter_err <= jerr_nx;
         mon.locked <= state == LOCKED;
         mon.clk_lost <= state == NO_CLK;
      end
`ifdef CLKMON_DUTY_EN
   logic [PERIOD_W-1:0] hcnt;
   logic seen_rise;
   always_ff @(posedge in_clk or negedge reset_n)
      if (!reset_n) begin
         hcnt <= '0;
         seen_rise <= 1'b0;
         mon.high_time <= '0;
         mon.high_valid <= 1'b0;
      end else begin
         hcnt <= rise ? '0 : (hcnt == MAX ? hcnt : hcnt + 1'b1);
         seen_rise <= rise | (seen_rise & ~timeout);
         if (fall) mon.high_time <= hcnt == MAX ? MAX : hcnt + 1'b1;
         mon.high_valid <= fall & seen_rise;
      end
`endif
endmodule
